// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and
// drives the IF/ID register, with a one-entry skid buffer and delay-slot redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WPCIR,
  input  logic        BRANCH,
  input  logic [31:0] BPC,
  output logic        IMREQ,
  output logic [31:0] IMADDR,
  input  logic        IMRDY,
  input  logic [31:0] IMDATA,
  output logic [31:0] IDIR,
  output logic [31:0] IDPC4,
  output logic        IDVALID
);

  typedef enum logic [1:0] {RUN, RUNBR, FULL} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] btgt_q, btgt_d;
  logic [31:0] sbuf_ir_q, sbuf_ir_d;
  logic [31:0] sbuf_pc4_q, sbuf_pc4_d;
  logic [31:0] idir_q, idir_d;
  logic [31:0] idpc4_q, idpc4_d;
  logic        idvalid_q, idvalid_d;

  logic [31:0] pc_plus4;
  logic [31:0] bpc_aligned;
  logic        xfer;
  logic        br_ok;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    btgt_d     = btgt_q;
    sbuf_ir_d  = sbuf_ir_q;
    sbuf_pc4_d = sbuf_pc4_q;
    idir_d     = idir_q;
    idpc4_d    = idpc4_q;
    idvalid_d  = idvalid_q;

    pc_plus4    = pc_q + 32'd4;
    bpc_aligned = BPC & ~32'd3;
    IMREQ       = !RST && (state_q != FULL);
    xfer        = IMREQ && IMRDY;
    br_ok       = BRANCH && !WPCIR && idvalid_q;

    if (xfer) begin
      // The word completing in RUNBR is the delay slot, so it resolves the pending redirect.
      if (state_q == RUNBR) pc_d = btgt_q;
      else if (br_ok)       pc_d = bpc_aligned;
      else                  pc_d = pc_plus4;

      if (WPCIR) begin
        sbuf_ir_d  = IMDATA;
        sbuf_pc4_d = pc_plus4;
        state_d    = FULL;
      end else begin
        idir_d    = IMDATA;
        idpc4_d   = pc_plus4;
        idvalid_d = 1'b1;
        state_d   = RUN;
      end
    end else begin
      if (!WPCIR) begin
        if (state_q == FULL) begin
          idir_d    = sbuf_ir_q;
          idpc4_d   = sbuf_pc4_q;
          idvalid_d = 1'b1;
          state_d   = RUN;
        end else begin
          idir_d    = NOP;
          idvalid_d = 1'b0;
        end
      end
      if (br_ok) begin
        // A full skid buffer already holds the delay slot; otherwise park the target.
        if (state_q == FULL) begin
          pc_d = bpc_aligned;
        end else begin
          btgt_d  = bpc_aligned;
          state_d = RUNBR;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC & ~32'd3;
      btgt_q     <= '0;
      sbuf_ir_q  <= '0;
      sbuf_pc4_q <= '0;
      idir_q     <= NOP;
      idpc4_q    <= '0;
      idvalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      btgt_q     <= btgt_d;
      sbuf_ir_q  <= sbuf_ir_d;
      sbuf_pc4_q <= sbuf_pc4_d;
      idir_q     <= idir_d;
      idpc4_q    <= idpc4_d;
      idvalid_q  <= idvalid_d;
    end
  end

  assign IMADDR  = pc_q;
  assign IDIR    = idir_q;
  assign IDPC4   = idpc4_q;
  assign IDVALID = idvalid_q;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode-stage controller. It owns the PC, issues word fetches to instruction memory over a request/ready handshake, and drives the IF/ID pipeline register (IDIR, IDPC4) consumed by decode. It obeys the decode stall (WPCIR) and the branch/jump redirect (BRANCH with target BPC) under a one-instruction branch delay slot. A one-entry skid buffer absorbs a fetch that completes while decode is stalled.

## Interface
- RESET_PC, 32'h00000000, first fetch address after reset
- NOP, 32'h00000000, bubble word loaded into IDIR when no instruction is available
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- WPCIR  in  1  decode stall: 1 = hold IDIR/IDPC4/IDVALID
- BRANCH  in  1  redirect request from decode (branch taken or jump)
- BPC  in  32  redirect target, valid with BRANCH
- IMREQ  out  1  fetch request to instruction memory
- IMADDR  out  32  fetch word address, equals PC
- IMRDY  in  1  memory ready; transfer completes in a cycle with IMREQ && IMRDY
- IMDATA  in  32  fetched word, valid when IMRDY=1
- IDIR  out  32  instruction presented to decode
- IDPC4  out  32  address of IDIR + 4
- IDVALID  out  1  IDIR holds a real instruction (0 = bubble)

## Operation
- States: RUN (requesting), RUNBR (requesting the delay slot, redirect pending in BTGT), FULL (skid buffer occupied, no request).
- IMREQ = 1 in RUN and RUNBR, 0 in FULL and while RST=1. IMADDR = PC. While IMREQ=1 and IMRDY=0, PC and IMADDR stay stable.
- Transfer (IMREQ && IMRDY):
  - WPCIR=0: IDIR <= IMDATA, IDPC4 <= PC+4, IDVALID <= 1.
  - WPCIR=1: SBUF <= {IMDATA, PC+4}, state -> FULL.
  - Next PC: BTGT if in RUNBR (state -> RUN), BPC if BRANCH is honored this cycle, else PC+4.
- No transfer, WPCIR=0: in FULL, IDIR/IDPC4 <= SBUF, IDVALID <= 1, state -> RUN. Otherwise IDIR <= NOP, IDVALID <= 0, IDPC4 held.
- WPCIR=1: IDIR, IDPC4 and IDVALID hold. FULL is held. In RUN/RUNBR, fetch continues until one transfer fills SBUF.
- BRANCH is honored only when WPCIR=0 and IDVALID=1; otherwise it is ignored. The delay slot is the instruction at IDPC4.
  - Delay slot already captured (transfer in this cycle, or SBUF full): PC <= BPC.
  - Delay slot still pending: BTGT <= BPC, state -> RUNBR. The next transfer is the delay slot, then PC <= BTGT.
- PC arithmetic is modulo 2^32. PC+4 wraps from 32'hFFFFFFFC to 0. Bits [1:0] of BPC are ignored; PC[1:0] is always 0.

## Timing
- Reset (async, immediate): PC=RESET_PC, IMADDR=RESET_PC, IMREQ=0, state=RUN, IDIR=NOP, IDPC4=0, IDVALID=0, BTGT=0, SBUF cleared.
- IMREQ rises combinationally once RST is low. The first fetch is at RESET_PC.
- Latency: with IMRDY tied 1 and no stall, IDIR is valid 1 cycle after the request cycle, and one instruction per cycle follows.
- Taken branch with zero-wait memory: branch in ID at cycle n, delay slot in ID at n+1, target in ID at n+2. No bubble.
- Reset asserted mid-transfer: the transfer is abandoned and no data is captured. Reset asserted in FULL: SBUF is discarded.
- Simultaneous transfer, WPCIR=1 and BRANCH: BRANCH is ignored, SBUF is filled, and the next PC is PC+4.
- In RUNBR with WPCIR=1 when the delay slot arrives: the delay slot goes to SBUF, PC <= BTGT, state -> FULL.

## Test plan
- Reset release with IMRDY=1 and RESET_PC=0 -> IMADDR sequence 0,4,8. At cycle 2, IDIR=mem[0], IDPC4=4, IDVALID=1.
- WPCIR=1 for 3 cycles at IDIR=mem[8] -> IDIR holds. Exactly one extra transfer (addr 12) goes to SBUF, then IMREQ=0. On release, IDIR=mem[12] with no bubble, and the next IMADDR is 16.
- BRANCH with BPC=32'h100 while the fetch at IDPC4 completes the same cycle -> next IMADDR is 32'h100. Decode sees branch, delay slot, then mem[0x100].
- IMRDY held 0 for 4 cycles at the delay-slot fetch, with BRANCH (BPC=32'h200) pulsed in the first of them -> IMADDR stays at the delay-slot address. Once it completes, IMADDR is 32'h200 and IDVALID=0 during the wait.
- PC at 32'hFFFFFFFC with IMRDY=1 -> next IMADDR is 0 and IDPC4 of that instruction is 0.
- RST pulsed while IMREQ=1, IMRDY=0 -> all outputs immediately take reset values. After release, the fetch restarts at RESET_PC.
